// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl -- instruction fetch sequencer.
//
// Owns the program counter, presents it to a combinational IMEM, and pushes
// each returned word together with its PC into a 2-entry fetch buffer. Decode
// drains the buffer through a valid/ready handshake. Handles start, branch
// redirect (with out-of-range fault), end-of-program detection and halt.
//
// Optional feature macro: FETCH_PERF_EN (adds perf_fetched / perf_stalls).
//
// Ports:
//   clk, rst           clock; asynchronous active-high reset
//   start              one-cycle pulse, (re)starts fetch at RESET_PC from IDLE/HALT
//   imem_pc            byte address to IMEM (always the PC register)
//   imem_instruction   word returned by IMEM for imem_pc, same cycle
//   redirect_valid/pc  branch/jump redirect; target bits [1:0] ignored
//   out_valid/ready    handshake to decode; out_instr/out_pc are the head entry
//   halted             high in HALT
//   fault              sticky out-of-range redirect flag
//   perf_fetched       (FETCH_PERF_EN) saturating push count
//   perf_stalls        (FETCH_PERF_EN) saturating full-buffer stall count
module imem_fetch_ctrl #(
  parameter int              ADDR_W    = 8,
  parameter int              MEM_WORDS = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] imem_pc,
  input  logic [31:0]       imem_instruction,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic              halted,
  output logic              fault
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]       perf_fetched,
  output logic [15:0]       perf_stalls
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, HALT} state_t;

  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(4 * MEM_WORDS - 4);
  localparam int unsigned       PC_LIMIT = 4 * MEM_WORDS;

  state_t            state, state_d;
  logic [ADDR_W-1:0] pc, pc_d;
  logic              fault_d;
  logic [1:0]        count;

  // Buffer entry 0 is always the head; entry 1 is only meaningful at count==2.
  logic [31:0]       b0_instr, b1_instr;
  logic [ADDR_W-1:0] b0_pc, b1_pc;

  logic              pop_raw, pop, push, flush, clear, stall;
  logic              push_ok;
  logic [1:0]        count_after;
  logic [ADDR_W-1:0] target;

  assign target      = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign pop_raw     = out_valid && out_ready;
  assign push_ok     = (count != 2'd2) || pop_raw;
  assign count_after = count - {1'b0, pop_raw};

  assign imem_pc   = pc;
  assign out_valid = (count != 2'd0);
  assign out_instr = b0_instr;
  assign out_pc    = b0_pc;
  assign halted    = (state == HALT);

  // NOTE: every signal driven here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state;
    pc_d    = pc;
    fault_d = fault;
    push    = 1'b0;
    flush   = 1'b0;
    clear   = 1'b0;
    stall   = 1'b0;
    unique case (state)
      IDLE, HALT: begin
        if (start) begin
          clear   = 1'b1;
          fault_d = 1'b0;
          pc_d    = RESET_PC;
          state_d = RUN;
        end
      end
      RUN, DRAIN: begin
        if (redirect_valid) begin
          flush = 1'b1;
          if (32'(target) >= PC_LIMIT) begin
            // Out-of-range target: PC is left alone so imem_pc stays legal.
            fault_d = 1'b1;
            state_d = HALT;
          end else begin
            pc_d    = target;
            state_d = RUN;
          end
        end else if (state == RUN) begin
          if (imem_instruction == 32'h0) begin
            state_d = DRAIN;                 // end marker: never buffered
          end else if (push_ok) begin
            push = 1'b1;
            if (pc == LAST_PC) state_d = DRAIN;   // no wrap past the last word
            else               pc_d    = pc + ADDR_W'(4);
          end else begin
            stall = 1'b1;
          end
        end else if (count_after == 2'd0) begin
          state_d = HALT;
        end
      end
      default: state_d = IDLE;
    endcase
    pop = pop_raw && !flush && !clear;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pc    <= RESET_PC;
      fault <= 1'b0;
    end else begin
      state <= state_d;
      pc    <= pc_d;
      fault <= fault_d;
    end
  end

  // NOTE: the buffer storage is reset too, because out_instr/out_pc must read
  // zero immediately on reset rather than showing stale contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= 2'd0;
      b0_instr <= '0;
      b0_pc    <= '0;
      b1_instr <= '0;
      b1_pc    <= '0;
    end else if (flush || clear) begin
      count <= 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            b0_instr <= imem_instruction;
            b0_pc    <= pc;
          end else begin
            b1_instr <= imem_instruction;
            b1_pc    <= pc;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          b0_instr <= b1_instr;
          b0_pc    <= b1_pc;
          count    <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            b0_instr <= imem_instruction;
            b0_pc    <= pc;
          end else begin
            b0_instr <= b1_instr;
            b0_pc    <= b1_pc;
            b1_instr <= imem_instruction;
            b1_pc    <= pc;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_stalls  <= '0;
    end else if (clear) begin
      perf_fetched <= '0;
      perf_stalls  <= '0;
    end else begin
      if (push && perf_fetched != 16'hFFFF) perf_fetched <= perf_fetched + 16'd1;
      if (stall && perf_stalls != 16'hFFFF) perf_stalls  <= perf_stalls + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl. Built with ADDR_W=9 so that a redirect
// to 0x100 (one word past a 64-word IMEM) is expressible on redirect_pc.
module tb_imem_fetch_ctrl;

  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] imem_pc;
  logic [31:0]   imem_instruction;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic [AW-1:0] out_pc;
  logic          halted;
  logic          fault;
`ifdef FETCH_PERF_EN
  logic [15:0]   perf_fetched;
  logic [15:0]   perf_stalls;
`endif

  logic [31:0] mem [64];
  int total = 0;
  int bad   = 0;

  imem_fetch_ctrl #(.ADDR_W(AW), .MEM_WORDS(64), .RESET_PC('0)) dut (
    .clk(clk), .rst(rst), .start(start), .imem_pc(imem_pc),
    .imem_instruction(imem_instruction), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .halted(halted), .fault(fault)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_stalls(perf_stalls)
`endif
  );

  always #5 clk = ~clk;

  // Combinational IMEM model; addresses past the array read as zero.
  always_comb begin
    if (imem_pc[AW-1:8] == 1'b0) imem_instruction = mem[imem_pc[7:2]];
    else                         imem_instruction = 32'h0;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_program(input int n);  // words 0..n-1 = 0x11*(i+1), rest 0
    for (int i = 0; i < 64; i++) mem[i] = (i < n) ? 32'(32'h11 * (i + 1)) : 32'h0;
  endtask

  task automatic wait_halt(input string name);
    int n = 0;
    while (!halted && n < 200) begin step(); n++; end
    total++;
    if (halted !== 1'b1) begin bad++; $display("FAIL %s_halt_timeout halted=%b want=1", name, halted); end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    load_program(3);
    #2;
    total++; if (imem_pc !== 9'h0)   begin bad++; $display("FAIL rst_pc got=%h want=0", imem_pc); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", out_valid); end
    total++; if (out_instr !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h want=0", out_instr); end
    total++; if (out_pc !== 9'h0)    begin bad++; $display("FAIL rst_outpc got=%h want=0", out_pc); end
    total++; if (halted !== 1'b0 || fault !== 1'b0) begin bad++; $display("FAIL rst_flags halted=%b fault=%b want=0,0", halted, fault); end
    @(negedge clk);
    rst = 1'b0;
    step();
    total++; if (out_valid !== 1'b0 || imem_pc !== 9'h0) begin bad++; $display("FAIL idle_hold valid=%b pc=%h want=0,0", out_valid, imem_pc); end
  endtask

  task automatic test_stream();
    load_program(3);
    out_ready = 1'b1;
    pulse_start();                              // now in t+1
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_t1_valid got=%b want=0", out_valid); end
    for (int k = 0; k < 3; k++) begin
      step();
      total++;
      if (out_valid !== 1'b1 || out_pc !== AW'(4 * k) || out_instr !== 32'(32'h11 * (k + 1))) begin
        bad++; $display("FAIL stream_%0d got v=%b pc=%h i=%h want 1,%h,%h", k, out_valid, out_pc, out_instr, 4 * k, 32'h11 * (k + 1));
      end
    end
    step();                                     // one cycle after last pop
    total++; if (out_valid !== 1'b0 || halted !== 1'b0) begin bad++; $display("FAIL stream_drain v=%b h=%b want 0,0", out_valid, halted); end
    step();                                     // two cycles after last pop
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL stream_halt got=%b want=1", halted); end
    total++; if (imem_pc !== 9'h00c) begin bad++; $display("FAIL stream_end_pc got=%h want=00c", imem_pc); end
  endtask

  task automatic test_backpressure();
    load_program(3);
    out_ready = 1'b0;
    pulse_start();                              // t+1
    for (int k = 0; k < 4; k++) step();         // t+5
    total++; if (imem_pc !== 9'h008) begin bad++; $display("FAIL bp_stall_pc got=%h want=008", imem_pc); end
    total++; if (out_valid !== 1'b1 || out_pc !== 9'h0 || out_instr !== 32'h11) begin bad++; $display("FAIL bp_head v=%b pc=%h i=%h want 1,0,11", out_valid, out_pc, out_instr); end
    step();
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (out_valid !== 1'b1 || out_pc !== AW'(4 * k) || out_instr !== 32'(32'h11 * (k + 1))) begin
        bad++; $display("FAIL bp_out_%0d got v=%b pc=%h i=%h want 1,%h,%h", k, out_valid, out_pc, out_instr, 4 * k, 32'h11 * (k + 1));
      end
      step();
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_no_dup got=%b want=0", out_valid); end
    wait_halt("bp");
  endtask

  task automatic test_redirect();
    for (int i = 0; i < 64; i++) mem[i] = (i < 8) ? 32'(32'hA0 + i) : 32'h0;
    out_ready = 1'b0;
    pulse_start();                              // t+1
    step(); step();                             // two entries buffered, stalled
    redirect_valid = 1'b1; redirect_pc = 9'h012;
    step();
    redirect_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL redir_flush got=%b want=0", out_valid); end
    total++; if (imem_pc !== 9'h010) begin bad++; $display("FAIL redir_pc got=%h want=010", imem_pc); end
    out_ready = 1'b1;
    step();
    total++; if (out_valid !== 1'b1 || out_pc !== 9'h010 || out_instr !== 32'hA4) begin bad++; $display("FAIL redir_target v=%b pc=%h i=%h want 1,010,a4", out_valid, out_pc, out_instr); end
    step();
    total++; if (out_pc !== 9'h014 || out_instr !== 32'hA5) begin bad++; $display("FAIL redir_next pc=%h i=%h want 014,a5", out_pc, out_instr); end
    wait_halt("redir");
    // Redirect has no effect once halted.
    redirect_valid = 1'b1; redirect_pc = 9'h004;
    step();
    redirect_valid = 1'b0;
    total++; if (halted !== 1'b1 || imem_pc !== 9'h020) begin bad++; $display("FAIL redir_in_halt h=%b pc=%h want 1,020", halted, imem_pc); end
  endtask

  task automatic test_fault();
    out_ready = 1'b1;
    pulse_start();                              // RUN
    redirect_valid = 1'b1; redirect_pc = 9'h100;
    step();
    redirect_valid = 1'b0;
    total++; if (fault !== 1'b1 || halted !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL fault_set f=%b h=%b v=%b want 1,1,0", fault, halted, out_valid); end
    step();
    total++; if (fault !== 1'b1) begin bad++; $display("FAIL fault_sticky got=%b want=1", fault); end
    pulse_start();
    total++; if (fault !== 1'b0 || halted !== 1'b0 || imem_pc !== 9'h0) begin bad++; $display("FAIL fault_restart f=%b h=%b pc=%h want 0,0,0", fault, halted, imem_pc); end
    step();
    total++; if (out_valid !== 1'b1 || out_pc !== 9'h0 || out_instr !== 32'hA0) begin bad++; $display("FAIL fault_first v=%b pc=%h i=%h want 1,0,a0", out_valid, out_pc, out_instr); end
    wait_halt("fault");
  endtask

  task automatic test_full_program();
    load_program(64);
    out_ready = 1'b1;
    pulse_start();
    for (int k = 0; k < 64; k++) begin
      step();
      if (out_valid !== 1'b1 || out_pc !== AW'(4 * k) || out_instr !== 32'(32'h11 * (k + 1))) begin
        bad++; $display("FAIL full_%0d got v=%b pc=%h i=%h want 1,%h,%h", k, out_valid, out_pc, out_instr, 4 * k, 32'h11 * (k + 1));
      end
      total++;
    end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL full_nowrap got v=%b pc=%h want v=0", out_valid, out_pc); end
    step();
    total++; if (halted !== 1'b1 || imem_pc !== 9'h0fc) begin bad++; $display("FAIL full_halt h=%b pc=%h want 1,0fc", halted, imem_pc); end
  endtask

  task automatic test_reset_mid();
    load_program(10);
    out_ready = 1'b0;
    pulse_start();
    step(); step();                             // buffer full, stalled at 8
    #3;
    rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_pc !== 9'h0) begin bad++; $display("FAIL midrst_out v=%b i=%h pc=%h want 0,0,0", out_valid, out_instr, out_pc); end
    total++; if (imem_pc !== 9'h0 || halted !== 1'b0 || fault !== 1'b0) begin bad++; $display("FAIL midrst_ctl pc=%h h=%b f=%b want 0,0,0", imem_pc, halted, fault); end
`ifdef FETCH_PERF_EN
    total++; if (perf_fetched !== 16'h0 || perf_stalls !== 16'h0) begin bad++; $display("FAIL midrst_perf f=%h s=%h want 0,0", perf_fetched, perf_stalls); end
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_fault();
    test_full_program();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Fetch controller that sequences the instruction memory for the core. It owns the program counter, drives the IMEM byte address, and captures each returned word plus its PC into a 2-entry fetch buffer. Decode consumes the buffer through a valid/ready handshake. The block handles start, branch redirect, end-of-program detection and halt between IMEM and decode.

## Interface
- `ADDR_W`, 8: PC / IMEM byte-address width.
- `MEM_WORDS`, 64: IMEM depth in 32-bit words; the legal PC range is 0 .. 4*MEM_WORDS-4.
- `RESET_PC`, 0: PC loaded on reset and on `start`.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse; begins fetching at `RESET_PC` from IDLE or HALT.
- `imem_pc`  out  ADDR_W  byte address to IMEM; the read is combinational, so the word is valid in the same cycle.
- `imem_instruction`  in  32  word returned by IMEM.
- `redirect_valid`  in  1  branch/jump redirect request.
- `redirect_pc`  in  ADDR_W  redirect target; bits [1:0] are ignored.
- `out_valid`  out  1  buffer head holds a valid instruction.
- `out_ready`  in  1  decode accepts the head this cycle.
- `out_instr`  out  32  head instruction.
- `out_pc`  out  ADDR_W  head PC.
- `halted`  out  1  high in HALT.
- `fault`  out  1  sticky; set by an out-of-range redirect; cleared by `rst` or `start`.

## Operation
- States:
  - IDLE (after reset).
  - RUN.
  - DRAIN (fetching stopped, buffer emptying).
  - HALT.
- IDLE→RUN on `start`: PC←`RESET_PC`, buffer cleared.
- HALT→RUN on `start`: same action; `fault` cleared.
- RUN, per cycle:
  - Push is allowed when count<2, or count==2 and a pop happens in the same cycle.
  - On push: {PC, `imem_instruction`} enters the buffer and PC←PC+4.
  - If no push is allowed, PC holds (stall).
- End-of-program:
  - A word of 0x00000000 at `imem_pc` in RUN is the end marker. It is never pushed; go to DRAIN. PC holds.
  - Pushing the word at PC = 4*MEM_WORDS-4 goes to DRAIN with no wrap; PC holds at that address.
- DRAIN→HALT when the buffer is empty (count==0 after this cycle's pop).
- Redirect:
  - In RUN or DRAIN, `redirect_valid` flushes the buffer (count←0, this cycle's pop and push suppressed), sets PC←{`redirect_pc`[ADDR_W-1:2],2'b00}, and goes to RUN.
  - If the aligned target is ≥ 4*MEM_WORDS: flush, set `fault`, go to HALT.
  - Redirect is ignored in IDLE and HALT.
- Priority: `rst` > redirect > start > end-of-program > push/pop.
- Pop happens when `out_valid && out_ready`. `out_*` are always the head entry; `out_instr`/`out_pc` are don't-care when `out_valid`=0.
- `imem_pc` = PC register in all states.
- Reset values: PC=`RESET_PC`, state=IDLE, count=0, `imem_pc`=`RESET_PC`, `out_valid`=0, `out_instr`=0, `out_pc`=0, `halted`=0, `fault`=0. Reset asserted mid-fetch discards the buffer immediately, without waiting for an edge.

## Timing
- `start` high at cycle t → RUN at t+1 → first push at the end of t+1 → `out_valid`=1 in t+2 with `out_pc`=`RESET_PC`.
- Throughput: one instruction per cycle with `out_ready` held high.
- Redirect at cycle t → `out_valid`=0 in t+1, `imem_pc`=target in t+1 → target instruction on `out_*` in t+2.
- Backpressure: with `out_ready` low, exactly 2 entries fill; after that PC holds, and the next accepted word follows in order with no loss or duplication.
- `halted` rises one cycle after the last pop in DRAIN.

## Configuration
- `FETCH_PERF_EN` defined: adds output ports `perf_fetched` [15:0] (pushes) and `perf_stalls` [15:0] (RUN cycles with push blocked by a full buffer). Both saturate at 0xFFFF, are zeroed by `rst` and `start`, and read 0 after reset.
- Not defined: the ports and counters are absent; all other behaviour is identical.

## Test plan
- IMEM words 0..3 = 0x11,0x22,0x33,0x0; `start`; `out_ready`=1 → pcs 0,4,8 with 0x11,0x22,0x33 on consecutive cycles from t+2; `halted`=1 two cycles after the last pop.
- Same program, `out_ready`=0 for 5 cycles after `start` → `imem_pc` stalls at 8 with count=2; on release, 0x11 and 0x22 emerge in order, then 0x33.
- Redirect to 0x12 while 2 entries are buffered → next `out_valid` shows `out_pc`=0x10; flushed entries are never seen.
- Redirect to 0x100 with MEM_WORDS=64 → `fault`=1, `halted`=1, `out_valid`=0; a later `start` clears `fault` and restarts at 0.
- All 64 words non-zero → last output has `out_pc`=0xFC, then HALT; no wrap to 0.
- Assert `rst` mid-stream between edges → all outputs reach their reset values immediately; with `FETCH_PERF_EN`, the counters read 0.
